gradient_wb_combine_buffer: RTL and testbench

- Parametrised next-generation writeback FIFO between the gradient accumulator and the DRAM write port.
- Generalises address/value width, depth and burst threshold over the current writeback buffer.
- Adds idle-timeout drain, an explicit flush handshake, and optional tail write-combining.
- Write-combining merges consecutive pushes to the same address with a saturating add, which cuts DRAM transactions for repeated gradient updates.

---
 rtl/gwb_pkg.sv | 31 +++
 rtl/gwb_sat_adder.sv | 24 ++
 rtl/gradient_wb_combine_buffer.sv | 140 ++++++++++++++
 tb/tb_gradient_wb_combine_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gwb_pkg.sv
// Shared types and helpers for gradient_wb_combine_buffer.
// Write-combining is enabled by defining GWB_WRITE_COMBINE_EN.
package gwb_pkg;

  localparam int GWB_ADDR_W = 32;
  localparam int GWB_VAL_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } gwb_state_e;

  typedef struct packed {
    logic [GWB_ADDR_W-1:0] addr;
    logic [GWB_VAL_W-1:0]  value;
  } gwb_entry_t;

  // Two's-complement add clamped to the signed range of GWB_VAL_W.
  function automatic logic [GWB_VAL_W-1:0] sat_add(input logic [GWB_VAL_W-1:0] a,
                                                   input logic [GWB_VAL_W-1:0] b);
    logic [GWB_VAL_W:0] sum;
    sum = {a[GWB_VAL_W-1], a} + {b[GWB_VAL_W-1], b};
    if (sum[GWB_VAL_W] != sum[GWB_VAL_W-1]) begin
      sat_add = sum[GWB_VAL_W] ? {1'b1, {(GWB_VAL_W-1){1'b0}}} : {1'b0, {(GWB_VAL_W-1){1'b1}}};
    end else begin
      sat_add = sum[GWB_VAL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/gwb_sat_adder.sv
// Combinational signed saturating adder; ovf_o flags a clamped result.
// Only instantiated when GWB_WRITE_COMBINE_EN is defined.
module gwb_sat_adder #(
  parameter int VAL_W = 32
) (
  input  logic [VAL_W-1:0] a_i,
  input  logic [VAL_W-1:0] b_i,
  output logic [VAL_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [VAL_W:0] sum_ext;

  always_comb begin
    sum_ext = {a_i[VAL_W-1], a_i} + {b_i[VAL_W-1], b_i};
    // The sign-extended carry disagrees with the result sign only on overflow.
    ovf_o   = sum_ext[VAL_W] ^ sum_ext[VAL_W-1];
    sum_o   = sum_ext[VAL_W-1:0];
    if (ovf_o) begin
      sum_o = sum_ext[VAL_W] ? {1'b1, {(VAL_W-1){1'b0}}} : {1'b0, {(VAL_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/gradient_wb_combine_buffer.sv
// Writeback FIFO between gradient accumulator and DRAM with burst/timeout/flush drain.
// Define GWB_WRITE_COMBINE_EN for saturating tail write-combining and sat_evt.
module gradient_wb_combine_buffer
  import gwb_pkg::*;
#(
  parameter int ADDR_W      = GWB_ADDR_W,
  parameter int VAL_W       = GWB_VAL_W,
  parameter int FIFO_DEPTH  = 32,
  parameter int BURST_SIZE  = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wb_push_valid,
  input  logic [ADDR_W-1:0]           wb_push_addr,
  input  logic [VAL_W-1:0]            wb_push_value,
  output logic                        wb_push_ready,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic                        dram_valid,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic [VAL_W-1:0]            dram_value,
  input  logic                        dram_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [1:0]                  state_o,
  output logic                        sat_evt
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;
  localparam int IDLE_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDLE_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_LAST_I[IDLE_W-1:0];
  localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     BURST_C   = CW'(BURST_SIZE);

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [VAL_W-1:0]  val_mem  [FIFO_DEPTH];

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  gwb_state_e        state_q, state_d;

  logic full, empty, push_acc, pop, alloc, timeout_hit;

  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign wb_push_ready = !full && (state_q != FLUSH);
  assign dram_valid    = (state_q != IDLE) && !empty;
  assign push_acc      = wb_push_valid && wb_push_ready;
  assign pop           = dram_valid && dram_ready;
  assign timeout_hit   = (TIMEOUT_CYC != 0) && (idle_q == IDLE_LAST) && !empty;
  assign dram_addr     = addr_mem[rd_ptr_q[AW-1:0]];
  assign dram_value    = val_mem[rd_ptr_q[AW-1:0]];
  assign fifo_count    = count_q;
  assign state_o       = state_q;
  assign flush_done    = (state_q == FLUSH) && empty;

`ifdef GWB_WRITE_COMBINE_EN
  logic [AW-1:0]    tail_idx;
  logic [VAL_W-1:0] merge_value;
  logic             merge_ovf, merge, sat_evt_q, sat_evt_d;

  assign tail_idx = wr_ptr_q[AW-1:0] - AW'(1);
  // The offered head must stay stable, so it is never a merge target.
  assign merge    = push_acc && !empty && (wb_push_addr == addr_mem[tail_idx]) &&
                    !(dram_valid && (count_q == CW'(1)));
  assign alloc    = push_acc && !merge;
  assign sat_evt_d = merge && merge_ovf;
  assign sat_evt   = sat_evt_q;

  gwb_sat_adder #(.VAL_W(VAL_W)) u_sat_adder (
    .a_i  (val_mem[tail_idx]),
    .b_i  (wb_push_value),
    .sum_o(merge_value),
    .ovf_o(merge_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_evt_q <= 1'b0;
    else        sat_evt_q <= sat_evt_d;
  end
`else
  assign alloc   = push_acc;
  assign sat_evt = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    state_d  = state_q;
    idle_d   = '0;
    wr_ptr_d = wr_ptr_q + CW'(alloc);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    count_d  = count_q + CW'(alloc) - CW'(pop);
    if ((state_q == IDLE) && !empty && !push_acc) idle_d = idle_q + IDLE_W'(1);
    unique case (state_q)
      IDLE: begin
        if (flush_req)                                       state_d = FLUSH;
        else if ((count_q >= BURST_C) || full || timeout_hit) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush_req)  state_d = FLUSH;
        else if (empty) state_d = IDLE;
      end
      FLUSH:   if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop update from pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idle_q   <= idle_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= wb_push_addr;
      val_mem[wr_ptr_q[AW-1:0]]  <= wb_push_value;
    end
`ifdef GWB_WRITE_COMBINE_EN
    else if (merge) begin
      val_mem[tail_idx] <= merge_value;
    end
`endif
  end

endmodule

// File: tb/tb_gradient_wb_combine_buffer.sv
// Randomised and directed bench for gradient_wb_combine_buffer against a queue-based model.
// Works with or without GWB_WRITE_COMBINE_EN defined.
module tb_gradient_wb_combine_buffer;
  import gwb_pkg::*;

  localparam int AW = 32, VW = 32, DEPTH = 32, BURST = 16, TMO = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam longint VMAX = (64'sd1 <<< 31) - 1;
  localparam longint VMIN = -(64'sd1 <<< 31);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wb_push_valid = 1'b0;
  logic [AW-1:0]    wb_push_addr = '0;
  logic [VW-1:0]    wb_push_value = '0;
  logic             wb_push_ready;
  logic             flush_req = 1'b0;
  logic             flush_done;
  logic             dram_valid;
  logic [AW-1:0]    dram_addr;
  logic [VW-1:0]    dram_value;
  logic             dram_ready = 1'b0;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       state_o;
  logic             sat_evt;

  always #5 clk = ~clk;

  gradient_wb_combine_buffer #(
    .ADDR_W(AW), .VAL_W(VW), .FIFO_DEPTH(DEPTH), .BURST_SIZE(BURST), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_push_valid(wb_push_valid), .wb_push_addr(wb_push_addr),
    .wb_push_value(wb_push_value), .wb_push_ready(wb_push_ready),
    .flush_req(flush_req), .flush_done(flush_done),
    .dram_valid(dram_valid), .dram_addr(dram_addr), .dram_value(dram_value),
    .dram_ready(dram_ready), .fifo_count(fifo_count), .state_o(state_o),
    .sat_evt(sat_evt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus the drain mode (0 idle, 1 drain, 2 flush).
  gwb_entry_t mq[$];
  int         m_mode, m_idle;
  bit         m_sat;

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_idle = 0;
    m_sat  = 1'b0;
  endtask

  task automatic model_step(input bit pv, input logic [31:0] pa, input logic [31:0] pd,
                            input bit fr, input bit dr);
    int         n;
    int         nm;
    bit         valid, rdy, acc, pop, merge;
    gwb_entry_t e;
    longint     s;
    n     = mq.size();
    valid = (m_mode != 0) && (n > 0);
    rdy   = (n < DEPTH) && (m_mode != 2);
    acc   = pv && rdy;
    pop   = valid && dr;
    merge = 1'b0;
    m_sat = 1'b0;
    nm    = m_mode;
`ifdef GWB_WRITE_COMBINE_EN
    if (acc && n > 0 && mq[n-1].addr == pa && !(valid && n == 1)) merge = 1'b1;
`endif
    case (m_mode)
      0: if (fr) nm = 2;
         else if (n >= BURST || n == DEPTH || (m_idle == TMO - 1 && n > 0)) nm = 1;
      1: if (fr) nm = 2; else if (n == 0) nm = 0;
      default: if (n == 0) nm = 0;
    endcase
    m_idle = (m_mode == 0 && n > 0 && !acc) ? m_idle + 1 : 0;
    if (merge) begin
      e = mq[n-1];
      s = longint'($signed(e.value)) + longint'($signed(pd));
      if (s > VMAX) begin s = VMAX; m_sat = 1'b1; end
      if (s < VMIN) begin s = VMIN; m_sat = 1'b1; end
      e.value = s[31:0];
      mq[n-1] = e;
    end
    if (pop) void'(mq.pop_front());
    if (acc && !merge) mq.push_back('{addr: pa, value: pd});
    m_mode = nm;
  endtask

  task automatic compare_outputs();
    int n;
    bit ev;
    n  = mq.size();
    ev = (m_mode != 0) && (n > 0);
    check("count", fifo_count, n);
    check("dram_valid", dram_valid, ev);
    check("push_ready", wb_push_ready, (n < DEPTH) && (m_mode != 2));
    check("state", state_o, m_mode);
    check("flush_done", flush_done, (m_mode == 2) && (n == 0));
    check("sat_evt", sat_evt, m_sat);
    if (ev) begin
      check("head_addr", dram_addr, mq[0].addr);
      check("head_value", dram_value, mq[0].value);
    end
  endtask

  bit         obs_valid, obs_ready, obs_fd, obs_sat;
  int         obs_count, fd_cnt, sat_cnt;
  logic [31:0] obs_addr, obs_value;
  gwb_entry_t pop_log[$];

  // One clock: check at negedge, drive inputs, then advance the model at posedge.
  task automatic cyc(input bit pv, input logic [31:0] pa, input logic [31:0] pd,
                     input bit fr, input bit dr);
    @(negedge clk);
    compare_outputs();
    obs_valid = dram_valid;
    obs_ready = wb_push_ready;
    obs_count = int'(fifo_count);
    obs_addr  = dram_addr;
    obs_value = dram_value;
    obs_fd    = flush_done;
    obs_sat   = sat_evt;
    if (flush_done) fd_cnt++;
    if (sat_evt) sat_cnt++;
    if (dram_valid && dr) pop_log.push_back('{addr: dram_addr, value: dram_value});
    wb_push_valid = pv;
    wb_push_addr  = pa;
    wb_push_value = pd;
    flush_req     = fr;
    dram_ready    = dr;
    @(posedge clk);
    model_step(pv, pa, pd, fr, dr);
  endtask

  task automatic drain_all(input string tag);
    int k;
    k = 0;
    while ((mq.size() != 0 || m_mode != 0) && k < 200) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      k++;
    end
    check(tag, k < 200, 1'b1);
  endtask

  task automatic random_phase(input int cycles);
    bit          pv, fr, dr;
    logic [31:0] pa, pd;
    for (int i = 0; i < cycles; i++) begin
      pv = ($urandom_range(99) < 60);
      pa = ($urandom_range(3) != 0) ? 32'(4 * $urandom_range(2)) : $urandom;
      case ($urandom_range(3))
        0:       pd = 32'h7FFF_FF00 + 32'($urandom_range(255));
        1:       pd = 32'h8000_0000 + 32'($urandom_range(255));
        default: pd = $urandom;
      endcase
      fr = ($urandom_range(99) < 2);
      dr = ((i / 200) % 2 == 0) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 20);
      cyc(pv, pa, pd, fr, dr);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    model_reset();
    fd_cnt  = 0;
    sat_cnt = 0;
    #12;
    check("rst_ready", wb_push_ready, 1'b1);
    check("rst_valid", dram_valid, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_state", state_o, 0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_sat", sat_evt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Burst trigger: valid appears one edge after the 16th push lands.
    pop_log.delete();
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 32'(100 + i), 1'b0, 1'b1);
    first = -1;
    for (int j = 1; j <= 40; j++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      if (first < 0 && obs_valid) first = j;
    end
    check("burst_delay", first, 2);
    check("burst_pops", pop_log.size(), 16);
    for (int i = 0; i < pop_log.size() && i < 16; i++) check("burst_order", pop_log[i].addr, i);
    check("burst_idle", state_o, 0);

    // Backpressure: fill to depth with DRAM stalled, then drain in order.
    pop_log.delete();
    for (int i = 0; i < 32; i++) cyc(1'b1, 32'h100 + 32'(i), 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h999, 32'h1, 1'b0, 1'b0);
    check("bp_full_ready", obs_ready, 1'b0);
    check("bp_full_count", obs_count, 32);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check("bp_no_33rd", obs_count, 32);
    check("bp_head_hold", obs_addr, 32'h100);
    for (int j = 0; j < 40; j++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check("bp_pops", pop_log.size(), 32);
    for (int i = 0; i < pop_log.size() && i < 32; i++) check("bp_order", pop_log[i].addr, 32'h100 + i);
    drain_all("bp_drain_bound");

    // Idle timeout: valid appears TMO edges after the last push.
    pop_log.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i), 32'(i), 1'b0, 1'b1);
    first = -1;
    for (int j = 1; j <= 30; j++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      if (first < 0 && obs_valid) first = j;
    end
    check("timeout_delay", first, TMO + 1);
    check("timeout_pops", pop_log.size(), 3);
    drain_all("timeout_drain_bound");

    // Flush with push_valid held, then flush of an empty FIFO.
    pop_log.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(i), 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h3F0, 32'd99, 1'b1, 1'b0);
    fd_cnt = 0;
    for (int j = 0; j < 20; j++) cyc(fd_cnt == 0, 32'h3F0, 32'd99, 1'b0, 1'b1);
    check("flush_pulses", fd_cnt, 1);
    check("flush_pops", pop_log.size(), 6);
    drain_all("flush_drain_bound");
    fd_cnt = 0;
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check("empty_flush_next", obs_fd, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check("empty_flush_once", fd_cnt, 1);

    // Tail combining and saturation.
    pop_log.delete();
    sat_cnt = 0;
    cyc(1'b1, 32'h40, 32'd5, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 32'd7, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 32'd1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef GWB_WRITE_COMBINE_EN
    check("comb_count", obs_count, 2);
    check("comb_head", obs_value, 12);
`else
    check("comb_count", obs_count, 3);
    check("comb_head", obs_value, 5);
`endif
    cyc(1'b1, 32'h40, 32'h7FFF_FFF0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 32'h0000_0100, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef GWB_WRITE_COMBINE_EN
    check("sat_pulse", obs_sat, 1'b1);
`else
    check("sat_pulse", obs_sat, 1'b0);
`endif
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    drain_all("comb_drain_bound");
`ifdef GWB_WRITE_COMBINE_EN
    check("sat_count", sat_cnt, 1);
    check("comb_pops", pop_log.size(), 3);
    if (pop_log.size() == 3) check("sat_value", pop_log[2].value, 32'h7FFF_FFFF);
`else
    check("sat_count", sat_cnt, 0);
    check("comb_pops", pop_log.size(), 5);
    if (pop_log.size() == 5) check("tail_value", pop_log[4].value, 32'h100);
`endif

    // Combine guard: the offered single head is never merged into.
    cyc(1'b1, 32'h80, 32'd3, 1'b0, 1'b0);
    first = -1;
    for (int j = 0; j < 20 && first < 0; j++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      if (obs_valid) first = j;
    end
    check("guard_offer", first >= 0, 1'b1);
    cyc(1'b1, 32'h80, 32'd4, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check("guard_count", obs_count, 2);
    check("guard_head", obs_value, 3);
    drain_all("guard_drain_bound");

    random_phase(3000);
    drain_all("rand_drain_bound");

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h500 + 32'(i), 32'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_valid", obs_valid, 1'b1);
    @(negedge clk);
    wb_push_valid = 1'b0;
    flush_req     = 1'b0;
    dram_ready    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", dram_valid, 1'b0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", wb_push_ready, 1'b1);
    check("mid_rst_state", state_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    random_phase(300);
    drain_all("final_drain_bound");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
